servo_pwm_bank: RTL and testbench

Parametrised multi-channel servo PWM generator for the robot-arm joints. One shared frame counter drives NUM_CH independent pulse outputs. Each channel takes a target pulse width over a valid/ready command port and clamps it to servo-safe limits. The live width slews toward the target by at most STEP cycles per frame, so joints never jump. Sits between the joint-command logic and the servo output pins.

---
 rtl/servo_pwm_bank_if.sv | 17 +
 rtl/servo_pwm_bank.sv | 154 +++++++++++++++
 tb/tb_servo_pwm_bank.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/servo_pwm_bank_if.sv
// Command port of servo_pwm_bank: valid/ready transfer of a (channel, width) pair
// plus the one-cycle error pulse for commands aimed at a non-existent channel.
interface servo_pwm_bank_if #(
    parameter int CH_W  = 3,
    parameter int CNT_W = 20
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [CH_W-1:0]  cmd_ch;
    logic [CNT_W-1:0] cmd_width;
    logic             cmd_err;

    modport master (output cmd_valid, output cmd_ch, output cmd_width,
                    input  cmd_ready, input  cmd_err);
    modport slave  (input  cmd_valid, input  cmd_ch, input  cmd_width,
                    output cmd_ready, output cmd_err);
endinterface

// File: rtl/servo_pwm_bank.sv
// Multi-channel servo PWM bank: shared frame counter, clamped per-channel targets,
// live widths slewed by at most STEP per frame. Optional sweep mode: SERVO_PWM_SWEEP_EN.
module servo_pwm_bank #(
    parameter int NUM_CH        = 5,
    parameter int CNT_W         = 20,
    parameter int PERIOD_CYCLES = 1000000,
    parameter int MIN_PULSE     = 50000,
    parameter int MAX_PULSE     = 100000,
    parameter int STEP          = 1000,
    parameter int CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
`ifdef SERVO_PWM_SWEEP_EN
    input  logic              sweep_en,
`endif
    servo_pwm_bank_if.slave   cmd,
    output logic [NUM_CH-1:0] pwm_out,
    output logic              frame_tick
);
    localparam logic [CNT_W-1:0] LAST_C   = CNT_W'(PERIOD_CYCLES - 1);
    localparam logic [CNT_W-1:0] MIN_C    = CNT_W'(MIN_PULSE);
    localparam logic [CNT_W-1:0] MAX_C    = CNT_W'(MAX_PULSE);
    localparam logic [CNT_W-1:0] CENTER_C = CNT_W'((MIN_PULSE + MAX_PULSE) / 2);
    localparam logic [CNT_W:0]   STEP_C   = (CNT_W+1)'(STEP);
    localparam logic [CH_W:0]    NUM_CH_C = (CH_W+1)'(NUM_CH);

    generate
        if (!((MIN_PULSE <= MAX_PULSE) && (MAX_PULSE < PERIOD_CYCLES) && (STEP >= 1))) begin : g_bad_cfg
            $error("servo_pwm_bank: need MIN_PULSE <= MAX_PULSE < PERIOD_CYCLES and STEP >= 1");
        end
    endgenerate

    function automatic logic [CNT_W-1:0] clamp_width(input logic [CNT_W-1:0] w);
        logic [CNT_W-1:0] r;
        if (w < MIN_C) begin
            r = MIN_C;
        end else if (w > MAX_C) begin
            r = MAX_C;
        end else begin
            r = w;
        end
        return r;
    endfunction

    // Work on the distance to the target so neither direction can wrap.
    function automatic logic [CNT_W-1:0] slew(input logic [CNT_W-1:0] live,
                                              input logic [CNT_W-1:0] tgt);
        logic [CNT_W:0] l_w;
        logic [CNT_W:0] t_w;
        logic [CNT_W:0] r_w;
        l_w = {1'b0, live};
        t_w = {1'b0, tgt};
        if (t_w > l_w) begin
            r_w = ((t_w - l_w) > STEP_C) ? (l_w + STEP_C) : t_w;
        end else if (t_w < l_w) begin
            r_w = ((l_w - t_w) > STEP_C) ? (l_w - STEP_C) : t_w;
        end else begin
            r_w = l_w;
        end
        return r_w[CNT_W-1:0];
    endfunction

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  target_q [NUM_CH];
    logic [CNT_W-1:0]  target_d [NUM_CH];
    logic [CNT_W-1:0]  live_q   [NUM_CH];
    logic [CNT_W-1:0]  live_d   [NUM_CH];
    logic [NUM_CH-1:0] pwm_q, pwm_d;
    logic              tick_q, tick_d;
    logic              err_q, err_d;
    logic              boundary_s, xfer_s, ch_ok_s;
`ifdef SERVO_PWM_SWEEP_EN
    logic [NUM_CH-1:0] dir_up_q, dir_up_d;
`endif

    // Ready drops with reset asynchronously, not on the next edge.
    assign boundary_s    = (cnt_q == LAST_C);
    assign cmd.cmd_ready = rst_n & ~boundary_s;
    assign xfer_s        = cmd.cmd_valid & cmd.cmd_ready;
    assign ch_ok_s       = ({1'b0, cmd.cmd_ch} < NUM_CH_C);

    assign pwm_out     = pwm_q;
    assign frame_tick  = tick_q;
    assign cmd.cmd_err = err_q;

    // Next-state: counter, command capture, frame-boundary slew and pulse compare.
    always_comb begin
        cnt_d  = boundary_s ? '0 : (cnt_q + CNT_W'(1));
        tick_d = boundary_s;
        err_d  = xfer_s & ~ch_ok_s;
        pwm_d  = '0;
`ifdef SERVO_PWM_SWEEP_EN
        dir_up_d = dir_up_q;
`endif
        for (int i = 0; i < NUM_CH; i++) begin
            pwm_d[i] = (cnt_q < live_q[i]);
            if (xfer_s && ch_ok_s && (cmd.cmd_ch == CH_W'(i))) begin
                target_d[i] = clamp_width(cmd.cmd_width);
            end else begin
                target_d[i] = target_q[i];
            end
            if (boundary_s) begin
`ifdef SERVO_PWM_SWEEP_EN
                if (sweep_en) begin
                    live_d[i] = slew(live_q[i], dir_up_q[i] ? MAX_C : MIN_C);
                    if (live_d[i] >= MAX_C) begin
                        dir_up_d[i] = 1'b0;
                    end else if (live_d[i] <= MIN_C) begin
                        dir_up_d[i] = 1'b1;
                    end else begin
                        dir_up_d[i] = dir_up_q[i];
                    end
                end else begin
                    live_d[i] = slew(live_q[i], target_q[i]);
                end
`else
                live_d[i] = slew(live_q[i], target_q[i]);
`endif
            end else begin
                live_d[i] = live_q[i];
            end
        end
    end

    // State registers; everything returns to CENTER / idle on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            pwm_q  <= '0;
            tick_q <= 1'b0;
            err_q  <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                target_q[i] <= CENTER_C;
                live_q[i]   <= CENTER_C;
            end
`ifdef SERVO_PWM_SWEEP_EN
            dir_up_q <= '1;
`endif
        end else begin
            cnt_q  <= cnt_d;
            pwm_q  <= pwm_d;
            tick_q <= tick_d;
            err_q  <= err_d;
            for (int i = 0; i < NUM_CH; i++) begin
                target_q[i] <= target_d[i];
                live_q[i]   <= live_d[i];
            end
`ifdef SERVO_PWM_SWEEP_EN
            dir_up_q <= dir_up_d;
`endif
        end
    end
endmodule

// File: tb/tb_servo_pwm_bank.sv
// Self-checking bench for servo_pwm_bank with shortened frames (1000 cycles, 100..200, step 10).
module tb_servo_pwm_bank;
    localparam int NUM_CH = 5;
    localparam int CNT_W  = 12;
    localparam int P      = 1000;
    localparam int MINP   = 100;
    localparam int MAXP   = 200;
    localparam int STEP   = 10;
    localparam int CH_W   = 3;
    localparam int CENTER = (MINP + MAXP) / 2;

    logic              clk;
    logic              rst_n;
    logic [NUM_CH-1:0] pwm_out;
    logic              frame_tick;
`ifdef SERVO_PWM_SWEEP_EN
    logic              sweep_en;
`endif

    servo_pwm_bank_if #(.CH_W(CH_W), .CNT_W(CNT_W)) bus ();

    servo_pwm_bank #(
        .NUM_CH(NUM_CH), .CNT_W(CNT_W), .PERIOD_CYCLES(P),
        .MIN_PULSE(MINP), .MAX_PULSE(MAXP), .STEP(STEP), .CH_W(CH_W)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
`ifdef SERVO_PWM_SWEEP_EN
        .sweep_en(sweep_en),
`endif
        .cmd(bus),
        .pwm_out(pwm_out),
        .frame_tick(frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: frame position, targets, live widths, measured high-cycle counts.
    int mcnt;
    int mtgt[NUM_CH];
    int mlive[NUM_CH];
    int frame_live[NUM_CH];
    int meas[NUM_CH];
    int last_meas[NUM_CH];
    bit rdy_seen;
    bit exp_err;

    typedef struct {
        bit                            do_cmd;
        int                            ch;
        int                            w;
        int                            frames;
        logic [NUM_CH-1:0][CNT_W-1:0]  exp;
    } vec_t;
    vec_t tbl[10];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic vec_t mk(input bit d, input int ch, input int w, input int fr,
                                input int e0, input int e1, input int e2, input int e3, input int e4);
        vec_t v;
        v.do_cmd = d; v.ch = ch; v.w = w; v.frames = fr;
        v.exp[0] = CNT_W'(e0); v.exp[1] = CNT_W'(e1); v.exp[2] = CNT_W'(e2);
        v.exp[3] = CNT_W'(e3); v.exp[4] = CNT_W'(e4);
        return v;
    endfunction

    function automatic int clampw(input int w);
        return (w < MINP) ? MINP : ((w > MAXP) ? MAXP : w);
    endfunction

    task automatic reset_model();
        mcnt    = 0;
        exp_err = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            mtgt[i] = CENTER; mlive[i] = CENTER; frame_live[i] = CENTER; meas[i] = 0;
        end
    endtask

    // Advance one clock: model the edge, then compare what the DUT shows at the negedge.
    task automatic cycle();
        bit xfer, bnd;
        int ch, w, d;
        xfer = bus.cmd_valid && rdy_seen;
        bnd  = (mcnt == P - 1);
        ch   = int'(bus.cmd_ch);
        w    = int'(bus.cmd_width);
        @(negedge clk);
        exp_err = xfer && (ch >= NUM_CH);
        if (xfer && ch < NUM_CH) mtgt[ch] = clampw(w);
        if (bnd) begin
            for (int i = 0; i < NUM_CH; i++) begin
                frame_live[i] = mlive[i];
                d = mtgt[i] - mlive[i];
                if (d > STEP) d = STEP;
                if (d < -STEP) d = -STEP;
                mlive[i] = mlive[i] + d;
            end
        end
        mcnt = (mcnt + 1) % P;
        chk("cmd_ready", bus.cmd_ready, (mcnt != P - 1));
        chk("frame_tick", frame_tick, (mcnt == 0));
        chk("cmd_err", bus.cmd_err, exp_err);
        for (int i = 0; i < NUM_CH; i++) meas[i] += int'(pwm_out[i]);
        if (mcnt == 0) begin
            for (int i = 0; i < NUM_CH; i++) begin
                chk($sformatf("width_ch%0d", i), meas[i], frame_live[i]);
                last_meas[i] = meas[i];
                meas[i] = 0;
            end
        end
        rdy_seen = bus.cmd_ready;
    endtask

    task automatic send(input int ch, input int w);
        bit done;
        done = 1'b0;
        bus.cmd_valid = 1'b1;
        bus.cmd_ch    = ch[CH_W-1:0];
        bus.cmd_width = w[CNT_W-1:0];
        for (int k = 0; k < 4 && !done; k++) begin
            done = rdy_seen;
            cycle();
        end
        chk("send_accepted", done, 1);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic run_frames(input int n);
        int k, g;
        k = 0; g = 0;
        while (k < n && g < (n + 1) * P) begin
            cycle();
            g++;
            if (mcnt == 0) k++;
        end
        chk("frame_budget", k, n);
    endtask

    task automatic wait_cnt(input int target);
        int g;
        g = 0;
        while (mcnt != target && g < P) begin
            cycle();
            g++;
        end
        chk("wait_cnt", mcnt, target);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

    initial begin
        bit done;
        rst_n = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_ch    = '0;
        bus.cmd_width = '0;
`ifdef SERVO_PWM_SWEEP_EN
        sweep_en = 1'b0;
`endif
        for (int i = 0; i < NUM_CH; i++) last_meas[i] = 0;
        repeat (3) @(negedge clk);
        chk("rst_pwm", pwm_out, 0);
        chk("rst_tick", frame_tick, 0);
        chk("rst_err", bus.cmd_err, 0);
        chk("rst_ready", bus.cmd_ready, 0);
        rst_n = 1'b1;
        reset_model();
        #1;
        rdy_seen = bus.cmd_ready;
        chk("ready_after_release", bus.cmd_ready, 1);

        tbl[0] = mk(1'b0, 0, 0,   1, 150, 150, 150, 150, 150);
        tbl[1] = mk(1'b1, 2, 180, 2, 150, 150, 160, 150, 150);
        tbl[2] = mk(1'b0, 0, 0,   1, 150, 150, 170, 150, 150);
        tbl[3] = mk(1'b0, 0, 0,   1, 150, 150, 180, 150, 150);
        tbl[4] = mk(1'b0, 0, 0,   1, 150, 150, 180, 150, 150);
        tbl[5] = mk(1'b1, 0, 20,  0, 0, 0, 0, 0, 0);
        tbl[6] = mk(1'b1, 1, 900, 2, 140, 160, 180, 150, 150);
        tbl[7] = mk(1'b0, 0, 0,   4, 100, 200, 180, 150, 150);
        tbl[8] = mk(1'b0, 0, 0,   1, 100, 200, 180, 150, 150);
        tbl[9] = mk(1'b1, 7, 120, 2, 100, 200, 180, 150, 150);

        for (int t = 0; t < 10; t++) begin
            if (tbl[t].do_cmd) begin
                repeat (300) cycle();
                send(tbl[t].ch, tbl[t].w);
            end
            if (tbl[t].frames > 0) begin
                run_frames(tbl[t].frames);
                for (int i = 0; i < NUM_CH; i++)
                    chk($sformatf("tbl%0d_ch%0d", t, i), last_meas[i], tbl[t].exp[i]);
            end
        end

        // Command raised in the boundary cycle: held off one cycle, accepted at counter 0.
        wait_cnt(P - 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_ch    = 3'd3;
        bus.cmd_width = 12'd170;
        #1;
        chk("ready_in_boundary", bus.cmd_ready, 0);
        cycle();
        chk("ready_at_cnt0", bus.cmd_ready, 1);
        done = rdy_seen;
        cycle();
        chk("xfer_at_cnt0", done, 1);
        bus.cmd_valid = 1'b0;
        run_frames(2);
        chk("boundary_cmd_ch3", last_meas[3], 160);

        // Randomised commands, including bad channels and out-of-range widths.
        for (int r = 0; r < 40; r++) begin
            repeat ($urandom_range(0, 200)) cycle();
            send(int'($urandom_range(0, 7)), int'($urandom_range(0, 1100)));
        end
        run_frames(3);

        // Reset mid-frame while every output is high.
        wait_cnt(60);
        chk("pwm_high_before_reset", pwm_out, {NUM_CH{1'b1}});
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_pwm", pwm_out, 0);
        chk("mid_rst_ready", bus.cmd_ready, 0);
        chk("mid_rst_tick", frame_tick, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        reset_model();
        #1;
        rdy_seen = bus.cmd_ready;
        run_frames(2);
        for (int i = 0; i < NUM_CH; i++)
            chk($sformatf("post_reset_ch%0d", i), last_meas[i], CENTER);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
